// File: rtl/params_pkg.sv
// Shared widths, instruction word type and fetch FSM encoding for the fetch front end.
// Pure type/constant definitions: no latency, no flow control.
package params_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int PADDR_WIDTH = 32;
    localparam int MEM_SIZE    = 65536;

    typedef logic [31:0] instruction_t;

    typedef enum logic [1:0] {
        ST_XLAT,
        ST_REQ,
        ST_WAIT,
        ST_KILL
    } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular {pc, instruction} FIFO; a pushed entry is visible at the head one cycle later.
// Push is ignored when full, pop when empty; flush empties it in one cycle and overrides push/pop.
module fetch_queue
    import params_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_pc_i,
    input  instruction_t             push_instr_i,
    input  logic                     pop_i,
    output logic [AW-1:0]            head_pc_o,
    output instruction_t             head_instr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_mem_q    [DEPTH];
    logic [AW-1:0] pc_mem_d    [DEPTH];
    instruction_t  instr_mem_q [DEPTH];
    instruction_t  instr_mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign count_o      = count_q;
    assign do_push      = push_i && !full_o;
    assign do_pop       = pop_i && !empty_o;
    // Empty queue presents zeros so decode never sees a stale entry.
    assign head_pc_o    = empty_o ? '0 : pc_mem_q[rd_ptr_q];
    assign head_instr_o = empty_o ? '0 : instr_mem_q[rd_ptr_q];

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                pc_mem_d[wr_ptr_q]    = push_pc_i;
                instr_mem_d[wr_ptr_q] = push_instr_i;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: XLAT->REQ->WAIT per instruction (>=3 cycles), one cache request in flight, DEPTH-entry queue to decode.
// Stops translating while queued+inflight fills the queue; redirect flushes and drains a stale response in KILL.
module fetch_queue_stage #(
    parameter int                    ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
    parameter int                    PADDR_WIDTH = params_pkg::PADDR_WIDTH,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(4096),
    parameter int                    MEM_SIZE    = params_pkg::MEM_SIZE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     redirect_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic                     xlat_req_o,
    output logic [ADDR_WIDTH-1:0]    xlat_vaddr_o,
    input  logic                     xlat_valid_i,
    input  logic [PADDR_WIDTH-1:0]   xlat_paddr_i,
    output logic                     ic_req_o,
    output logic [PADDR_WIDTH-1:0]   ic_addr_o,
    input  logic                     ic_ready_i,
    input  logic                     ic_rvalid_i,
    input  logic [31:0]              ic_rdata_i,
    output logic                     ic_flush_o,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [ADDR_WIDTH-1:0]    dec_pc_o,
    output params_pkg::instruction_t dec_instr_o
);
    import params_pkg::*;

    localparam int                    CW      = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_MASK = ADDR_WIDTH'(MEM_SIZE - 1);

    fetch_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic                    inflight_q, inflight_d;
    logic [CW-1:0]           q_count;
    logic                    q_empty, q_full;
    logic [CW:0]             slots_used;
    logic                    has_room, ic_accept, enq, deq;

    // An accepted request already owns a queue slot, so it can never be dropped on return.
    assign slots_used   = {1'b0, q_count} + (CW+1)'(inflight_q);
    assign has_room     = slots_used < (CW+1)'(DEPTH);

    assign xlat_req_o   = (state_q == ST_XLAT) && has_room;
    assign xlat_vaddr_o = fetch_pc_q;
    assign ic_req_o     = (state_q == ST_REQ);
    assign ic_addr_o    = paddr_q;
    assign ic_accept    = ic_req_o && ic_ready_i;
    assign ic_flush_o   = redirect_i && !rst_i;
    assign enq          = (state_q == ST_WAIT) && ic_rvalid_i && !redirect_i && !q_full;
    assign dec_valid_o  = !q_empty;
    assign deq          = dec_valid_o && dec_ready_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        paddr_d    = paddr_q;
        inflight_d = inflight_q;
        unique case (state_q)
            ST_XLAT: begin
                if (xlat_req_o && xlat_valid_i) begin
                    paddr_d = xlat_paddr_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ic_accept) begin
                    inflight_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ic_rvalid_i) begin
                    fetch_pc_d = (fetch_pc_q + ADDR_WIDTH'(4)) & PC_MASK;
                    inflight_d = 1'b0;
                    state_d    = ST_XLAT;
                end
            end
            ST_KILL: begin
                if (ic_rvalid_i) begin
                    inflight_d = 1'b0;
                    state_d    = ST_XLAT;
                end
            end
            default: state_d = ST_XLAT;
        endcase
        // Anything accepted by the cache and not answered this cycle must be drained in KILL.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            if ((inflight_q && !ic_rvalid_i) || ic_accept) begin
                inflight_d = 1'b1;
                state_d    = ST_KILL;
            end else begin
                inflight_d = 1'b0;
                state_d    = ST_XLAT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_XLAT;
            fetch_pc_q <= RESET_PC;
            paddr_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            paddr_q    <= paddr_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .push_i       (enq),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (ic_rdata_i),
        .pop_i        (deq),
        .head_pc_o    (dec_pc_o),
        .head_instr_o (dec_instr_o),
        .count_o      (q_count),
        .empty_o      (q_empty),
        .full_o       (q_full)
    );
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: reset/latency vector table, hand-built redirect/full/reset corners,
// then random traffic checked against a PC-sequence scoreboard and a one-outstanding cache model.
module tb_fetch_queue_stage;
    localparam int MEM = 8192;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        xlat_req_o;
    logic [31:0] xlat_vaddr_o;
    logic        xlat_valid_i = 1'b0;
    logic [31:0] xlat_paddr_i = '0;
    logic        ic_req_o;
    logic [31:0] ic_addr_o;
    logic        ic_ready_i = 1'b0;
    logic        ic_rvalid_i = 1'b0;
    logic [31:0] ic_rdata_i = '0;
    logic        ic_flush_o;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_instr_o;

    always #5 clk_i = ~clk_i;

    fetch_queue_stage #(
        .ADDR_WIDTH  (32),
        .PADDR_WIDTH (32),
        .DEPTH       (4),
        .RESET_PC    (32'd4096),
        .MEM_SIZE    (MEM)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .xlat_req_o    (xlat_req_o),
        .xlat_vaddr_o  (xlat_vaddr_o),
        .xlat_valid_i  (xlat_valid_i),
        .xlat_paddr_i  (xlat_paddr_i),
        .ic_req_o      (ic_req_o),
        .ic_addr_o     (ic_addr_o),
        .ic_ready_i    (ic_ready_i),
        .ic_rvalid_i   (ic_rvalid_i),
        .ic_rdata_i    (ic_rdata_i),
        .ic_flush_o    (ic_flush_o),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Environment knobs (percent / per-mille) and cache response delay range.
    int p_xv = 100, p_ir = 100, p_dr = 100, p_redir = 0, dmin = 0, dmax = 0;
    logic        one_redir = 1'b0;
    logic [31:0] one_tgt = '0;

    // Cache model: one outstanding request, data derived from the address it was given.
    logic        c_pend = 1'b0, c_poison = 1'b0;
    logic [31:0] c_addr = '0;
    int          c_dly = 0, n_acc = 0;

    // Scoreboard: decode must see consecutive PCs from the last redirect/reset target.
    logic [31:0] exp_pc = 32'd4096;
    logic        hold_prev = 1'b0, redir_prev = 1'b0;
    logic [31:0] held_pc = '0, held_instr = '0, redir_tgt_prev = '0;
    logic [31:0] deq_log[$];
    int          n_deq = 0;

    typedef struct {
        logic        xv;
        logic        rv;
        logic [31:0] rdata;
        logic        xreq;
        logic [31:0] vaddr;
        logic        icreq;
        logic        dv;
        logic [31:0] dpc;
        logic [31:0] dins;
    } vec_t;
    vec_t tv[10];

    function automatic logic [31:0] xfn(input logic [31:0] v);
        return v ^ 32'h0008_0000;
    endfunction

    function automatic logic [31:0] cfn(input logic [31:0] p);
        return {p[15:0], p[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] exp);
        if (deq_log.size() > idx) chk(nm, deq_log[idx], exp);
        else chk({nm, "_missing"}, 32'hFFFF_FFFF, exp);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        redirect_i = 1'b0; xlat_valid_i = 1'b0; ic_ready_i = 1'b0;
        ic_rvalid_i = 1'b0; dec_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_pc = 32'd4096; hold_prev = 1'b0; redir_prev = 1'b0;
    endtask

    task automatic post_reset_checks(input string tag);
        chk({tag, "_dv"},    32'(dec_valid_o), 0);
        chk({tag, "_icreq"}, 32'(ic_req_o), 0);
        chk({tag, "_flush"}, 32'(ic_flush_o), 0);
        chk({tag, "_xreq"},  32'(xlat_req_o), 1);
        chk({tag, "_vaddr"}, xlat_vaddr_o, 32'd4096);
    endtask

    // One clock of environment + scoreboard; entered and left at posedge+1.
    task automatic cyc();
        logic        dv;
        logic [31:0] dpc, dins;
        dv = dec_valid_o; dpc = dec_pc_o; dins = dec_instr_o;
        if (redir_prev) begin
            chk("dv_after_redirect", 32'(dv), 0);
            chk("xreq_after_redirect", 32'(xlat_req_o), 32'(!c_pend));
            if (!c_pend) chk("vaddr_after_redirect", xlat_vaddr_o, redir_tgt_prev);
        end
        if (hold_prev) begin
            chk("hold_valid", 32'(dv), 1);
            chk("hold_pc", dpc, held_pc);
            chk("hold_instr", dins, held_instr);
        end
        if (c_pend) chk("one_inflight", 32'(ic_req_o), 0);
        if (!dv) chk("empty_zero", dpc | dins, 0);

        xlat_valid_i  = xlat_req_o && ($urandom_range(0, 99) < p_xv);
        xlat_paddr_i  = xfn(xlat_vaddr_o);
        ic_ready_i    = ($urandom_range(0, 99) < p_ir);
        ic_rvalid_i   = c_pend && (c_dly == 0);
        ic_rdata_i    = c_poison ? 32'hDEAD_BEEF : cfn(c_addr);
        dec_ready_i   = ($urandom_range(0, 99) < p_dr);
        redirect_i    = one_redir || ($urandom_range(0, 999) < p_redir);
        redirect_pc_i = one_redir ? one_tgt : (32'($urandom_range(0, 2047)) << 2);
        one_redir     = 1'b0;
        #1;
        chk("flush", 32'(ic_flush_o), 32'(redirect_i));
        if (dv && dec_ready_i) begin
            deq_log.push_back(dpc);
            n_deq++;
            chk("deq_pc", dpc, exp_pc);
            chk("deq_instr", dins, cfn(xfn(dpc)));
            exp_pc = (exp_pc + 32'd4) % 32'(MEM);
        end
        if (redirect_i) exp_pc = redirect_pc_i;
        hold_prev      = dv && !dec_ready_i && !redirect_i;
        held_pc        = dpc;
        held_instr     = dins;
        redir_prev     = redirect_i;
        redir_tgt_prev = redirect_pc_i;

        if (ic_rvalid_i) begin
            c_pend = 1'b0; c_poison = 1'b0;
        end else if (c_pend && c_dly > 0) begin
            c_dly--;
        end
        if (ic_req_o && ic_ready_i) begin
            c_pend = 1'b1; c_addr = ic_addr_o;
            c_dly = int'($urandom_range(dmax, dmin)); n_acc++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wait_accept(input string nm);
        for (int k = 0; k < 40 && !c_pend; k++) cyc();
        chk(nm, 32'(c_pend), 1);
    endtask

    initial begin
        // Cycle-by-cycle startup: 1-cycle translation and cache, decode always ready.
        tv[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'd4096, 1'b0, 1'b0, 32'd0,    32'h0};
        tv[1] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'd4096, 1'b1, 1'b0, 32'd0,    32'h0};
        tv[2] = '{1'b1, 1'b1, 32'hA000_0001, 1'b0, 32'd4096, 1'b0, 1'b0, 32'd0,    32'h0};
        tv[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'd4100, 1'b0, 1'b1, 32'd4096, 32'hA000_0001};
        tv[4] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'd4100, 1'b1, 1'b0, 32'd0,    32'h0};
        tv[5] = '{1'b1, 1'b1, 32'hB000_0002, 1'b0, 32'd4100, 1'b0, 1'b0, 32'd0,    32'h0};
        tv[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'd4104, 1'b0, 1'b1, 32'd4100, 32'hB000_0002};
        tv[7] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'd4104, 1'b1, 1'b0, 32'd0,    32'h0};
        tv[8] = '{1'b1, 1'b1, 32'hC000_0003, 1'b0, 32'd4104, 1'b0, 1'b0, 32'd0,    32'h0};
        tv[9] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'd4108, 1'b0, 1'b1, 32'd4104, 32'hC000_0003};

        // Reset must dominate a simultaneous redirect.
        rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        @(posedge clk_i); #1;
        chk("rst_flush_masked", 32'(ic_flush_o), 0);
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        do_reset();
        post_reset_checks("reset");

        for (int i = 0; i < 10; i++) begin
            xlat_valid_i = tv[i].xv;
            xlat_paddr_i = xfn(xlat_vaddr_o);
            ic_ready_i   = 1'b1;
            ic_rvalid_i  = tv[i].rv;
            ic_rdata_i   = tv[i].rdata;
            dec_ready_i  = 1'b1;
            redirect_i   = 1'b0;
            #1;
            chk($sformatf("row%0d_xreq", i),  32'(xlat_req_o),  32'(tv[i].xreq));
            chk($sformatf("row%0d_vaddr", i), xlat_vaddr_o,     tv[i].vaddr);
            chk($sformatf("row%0d_icreq", i), 32'(ic_req_o),    32'(tv[i].icreq));
            chk($sformatf("row%0d_dv", i),    32'(dec_valid_o), 32'(tv[i].dv));
            chk($sformatf("row%0d_dpc", i),   dec_pc_o,         tv[i].dpc);
            chk($sformatf("row%0d_dins", i),  dec_instr_o,      tv[i].dins);
            @(posedge clk_i); #1;
        end
        ic_rvalid_i = 1'b0;

        // Decode stalled: queue fills to DEPTH and translation stops, then drains in order.
        do_reset();
        p_xv = 100; p_ir = 100; p_dr = 0; p_redir = 0; dmin = 0; dmax = 0;
        for (int k = 0; k < 30; k++) begin
            if (k >= 15) begin
                chk("full_no_xreq", 32'(xlat_req_o), 0);
                chk("full_head_pc", dec_pc_o, 32'd4096);
            end
            cyc();
        end
        p_dr = 100;
        deq_log.delete();
        run(20);
        for (int i = 0; i < 5; i++) chk_log($sformatf("drain%0d", i), i, 32'd4096 + 32'(4 * i));

        // Redirect while waiting on a slow cache: the late response is poisoned and must vanish.
        do_reset();
        dmin = 3; dmax = 3;
        wait_accept("reach_wait");
        c_poison = 1'b1; one_redir = 1'b1; one_tgt = 32'h2000;
        cyc();
        deq_log.delete();
        chk("kill_no_xreq", 32'(xlat_req_o), 0);
        dmin = 0; dmax = 0;
        run(25);
        chk_log("redir_head", 0, 32'h2000);

        // Redirect in the same cycle as the response: dropped, no KILL.
        do_reset();
        dmin = 1; dmax = 1;
        wait_accept("reach_wait2");
        cyc();
        dmin = 0; dmax = 0;
        c_poison = 1'b1; one_redir = 1'b1; one_tgt = 32'h0100;
        cyc();
        deq_log.delete();
        chk("coinc_xreq", 32'(xlat_req_o), 1);
        chk("coinc_vaddr", xlat_vaddr_o, 32'h0100);
        run(20);
        chk_log("coinc_head", 0, 32'h0100);
        chk_log("coinc_next", 1, 32'h0104);

        // PC wraps modulo the memory size.
        one_redir = 1'b1; one_tgt = 32'd8188;
        cyc();
        deq_log.delete();
        run(30);
        chk_log("wrap_first", 0, 32'd8188);
        chk_log("wrap_second", 1, 32'd0);

        // Reset while a response is outstanding and the queue holds three entries.
        do_reset();
        p_dr = 0; dmin = 3; dmax = 3; n_acc = 0;
        for (int k = 0; k < 80 && n_acc < 4; k++) cyc();
        chk("reach_4th_accept", 32'(n_acc), 4);
        chk("pre_reset_dv", 32'(dec_valid_o), 1);
        do_reset();
        post_reset_checks("midrst");
        p_xv = 0;
        run(5);
        chk("stale_delivered", 32'(c_pend), 0);
        p_xv = 100; p_dr = 100; dmin = 0; dmax = 0;
        deq_log.delete();
        run(20);
        chk_log("midrst_head", 0, 32'd4096);
        chk_log("midrst_next", 1, 32'd4100);

        // Random traffic with random redirects.
        do_reset();
        p_xv = 60; p_ir = 60; p_dr = 60; p_redir = 30; dmin = 0; dmax = 3; n_deq = 0;
        run(3000);
        chk("liveness", 32'(n_deq > 100), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
